// File: rtl/store_merge.sv
`default_nettype none
// ============================================================================
// Module   : store_merge
// Brief    : Sub-word store unit; byte/half stores via read-modify-write.
// Revision : 1.0
// ============================================================================
module store_merge #(
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic [ADDR_WIDTH-1:0] req_addr_i,
    input  logic [31:0]           req_data_i,
    input  logic [1:0]            req_size_i,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic                  mem_re_o,
    input  logic                  mem_rvalid_i,
    input  logic [31:0]           mem_rdata_i,
    output logic                  mem_we_o,
    output logic [31:0]           mem_wdata_o,
    output logic                  done_o,
    output logic                  err_o
);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_READ  = 2'd1;
    localparam logic [1:0] c_WRITE = 2'd2;
    localparam logic [1:0] c_DONE  = 2'd3;

    localparam logic [1:0] c_SZ_BYTE = 2'b00;
    localparam logic [1:0] c_SZ_HALF = 2'b01;
    localparam logic [1:0] c_SZ_WORD = 2'b10;

    logic [1:0]            state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q,  addr_d;
    logic [15:0]           data_q,  data_d;
    logic [1:0]            size_q,  size_d;
    logic                  err_q,   err_d;
    logic [31:0]           wbuf_q,  wbuf_d;
    logic                  illegal;
    logic [31:0]           merged;

    assign illegal = (req_size_i == 2'b11)
                   || ((req_size_i == c_SZ_HALF) && req_addr_i[0])
                   || ((req_size_i == c_SZ_WORD) && (req_addr_i[1:0] != 2'b00));

    // Only the low halfword of the store data can ever reach memory on the RMW path.
    always_comb begin
        merged = mem_rdata_i;
        case (size_q)
            c_SZ_BYTE: begin
                case (addr_q[1:0])
                    2'b00:   merged[7:0]   = data_q[7:0];
                    2'b01:   merged[15:8]  = data_q[7:0];
                    2'b10:   merged[23:16] = data_q[7:0];
                    default: merged[31:24] = data_q[7:0];
                endcase
            end
            c_SZ_HALF: begin
                if (addr_q[1]) merged[31:16] = data_q;
                else           merged[15:0]  = data_q;
            end
            default: merged = mem_rdata_i;
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= c_IDLE;
            addr_q  <= '0;
            data_q  <= '0;
            size_q  <= '0;
            err_q   <= 1'b0;
            wbuf_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            size_q  <= size_d;
            err_q   <= err_d;
            wbuf_q  <= wbuf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        data_d  = data_q;
        size_d  = size_q;
        err_d   = err_q;
        wbuf_d  = wbuf_q;
        case (state_q)
            c_IDLE: begin
                if (req_valid_i) begin
                    addr_d = req_addr_i;
                    data_d = req_data_i[15:0];
                    size_d = req_size_i;
                    err_d  = illegal;
                    wbuf_d = req_data_i;
                    if (illegal)                       state_d = c_DONE;
                    else if (req_size_i == c_SZ_WORD)  state_d = c_WRITE;
                    else                               state_d = c_READ;
                end
            end
            c_READ: begin
                if (mem_rvalid_i) begin
                    wbuf_d  = merged;
                    state_d = c_WRITE;
                end
            end
            c_WRITE: state_d = c_DONE;
            default: state_d = c_IDLE;
        endcase
    end

    always_comb begin
        req_ready_o = 1'b0;
        mem_re_o    = 1'b0;
        mem_we_o    = 1'b0;
        done_o      = 1'b0;
        err_o       = 1'b0;
        case (state_q)
            c_IDLE:  req_ready_o = 1'b1;
            c_READ:  mem_re_o    = 1'b1;
            c_WRITE: mem_we_o    = 1'b1;
            default: begin
                done_o = 1'b1;
                err_o  = err_q;
            end
        endcase
    end

    assign mem_addr_o  = {addr_q[ADDR_WIDTH-1:2], 2'b00};
    assign mem_wdata_o = wbuf_q;

endmodule
`default_nettype wire
